jstk_spi_responder: RTL and testbench
=====================================

Name: jstk_spi_responder

Overview:
- SPI slave (responder) emulating the PmodJSTK joystick. It answers the joystick_top master's 5-byte frames (SS/MOSI/SCLK in, MISO out) with programmable X/Y/button data, and it decodes the master's LED command byte.
- Used in simulation benches and as an on-board loopback target. This lets the joystick path and its debug outputs be exercised without the physical Pmod.
- All SPI inputs are asynchronous to clk: they are oversampled, synchronized and edge-detected internally.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizers on ss_n/sclk/mosi (minimum 2).
- IDLE_MISO, 1'b0, value driven on miso while deselected or after the 40th bit.

Ports:
- clk  input  1  system clock; SPI SCLK must be ≤ clk/8.
- rst  input  1  synchronous, active-high reset.
- ss_n  input  1  slave select from master, active low.
- sclk  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0).
- mosi  input  1  master-out data, MSB first.
- miso  output  1  slave-out data, MSB first.
- x_pos  input  10  X value to report; snapshotted at frame start.
- y_pos  input  10  Y value to report; snapshotted at frame start.
- btn  input  3  {btn2, btn1, stick_btn}; snapshotted at frame start.
- led  output  2  {led2, led1} from the last accepted command byte.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse on a clean 40-bit frame end.
- frame_err  output  1  one-cycle pulse on an aborted or overlong frame.

Behaviour:
- Reset values: miso=IDLE_MISO, led=0, busy=0, frame_done=0, frame_err=0, bit_cnt=0, state=IDLE, armed=0.
- Inputs pass through SYNC_STAGES flops plus one history flop. Edges are detected on the synchronized signals.
- Transmit frame (40 bits, MSB first):
  - byte0 = x[7:0]
  - byte1 = {6'b0, x[9:8]}
  - byte2 = y[7:0]
  - byte3 = {6'b0, y[9:8]}
  - byte4 = {5'b0, btn}
- State machine:
  - IDLE: armed is set once synchronized ss_n is seen high. On an ss_n falling edge while armed: snapshot x/y/btn into the 40-bit tx shift register, drive miso=tx[39] in the same cycle as the edge detect, clear bit_cnt and rx, set busy, and go to SHIFT.
  - SHIFT, SCLK rising: rx <= {rx[6:0], mosi_sync}, bit_cnt++. When bit_cnt reaches 8, latch rx into cmd_byte.
  - SHIFT, SCLK falling: if bit_cnt < 40, shift tx left and drive miso = new tx[39]; otherwise miso=IDLE_MISO.
  - SHIFT, ss_n rising edge with bit_cnt==40: pulse frame_done; if cmd_byte is valid, led <= cmd_byte[1:0]; go to IDLE.
  - SHIFT, ss_n rising edge with bit_cnt≠40: pulse frame_err; led unchanged; go to IDLE.
  - SHIFT, SCLK rising while bit_cnt==40: extra bits are ignored; bit_cnt saturates at 40; a sticky overrun flag is set. The frame then ends with frame_err instead of frame_done, and led is not updated.
- busy=1 in SHIFT, 0 in IDLE. miso=IDLE_MISO in IDLE.
- SCLK edges in IDLE are ignored.
- If an SCLK edge and an ss_n rise are detected in the same cycle, the ss_n rise wins and the SCLK edge is discarded.
- Latency: miso updates SYNC_STAGES+1 clk cycles after the pin-level SCLK falling edge. frame_done/frame_err assert SYNC_STAGES+1 cycles after ss_n rises.
- Reset mid-frame: everything returns to reset values and armed=0. The in-flight frame is dropped with no pulse. A new frame is accepted only after ss_n has been seen high.
- Changes to x/y/btn during a frame do not affect the frame being sent.

Optional Feature:
- Macro: JSTK_CMD_CHECK_EN.
- Defined: cmd_byte is valid only if cmd_byte[7:2]==6'b100000. An invalid command leaves led unchanged and the frame still reports frame_done.
- Undefined: every complete frame updates led <= cmd_byte[1:0] regardless of the upper bits.

Test Plan:
- x=10'h2A5, y=10'h13C, btn=3'b101, master sends 8'h83 then 4×8'h00 at clk/8 → MISO bytes A5,02,3C,01,05; frame_done one pulse; led=2'b11; busy low afterwards.
- Change x to 10'h3FF mid-frame after byte 1 → the frame still carries A5,02; the next frame carries FF,03.
- SS raised after 17 bits → frame_err pulse, no frame_done, led unchanged, busy drops, miso=IDLE_MISO.
- 41 SCLK cycles in one frame → 41st bit reads IDLE_MISO; frame_err at SS rise; led unchanged.
- Command 8'h41 with JSTK_CMD_CHECK_EN defined → led stays at its prior value, frame_done pulses. Without the macro → led=2'b01.
- Assert rst for 1 cycle after bit 20 → outputs at reset values, no pulses. SS held low after rst → no response. Next SS low→high→low frame works normally.

Source files
------------

// File: rtl/jstk_spi_responder.sv
// PmodJSTK-compatible SPI responder: returns X/Y/button data in 5-byte frames and decodes LEDs.
// Optional JSTK_CMD_CHECK_EN: accept only commands whose upper six bits are 6'b100000.
module jstk_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        IDLE_MISO   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss_n,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] btn,
    output logic [1:0] led,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    localparam logic [5:0] FrameBits = 6'd40;

    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   ss_hist_q, ss_hist_d;
    logic                   sclk_hist_q, sclk_hist_d;

    state_e      state_q, state_d;
    logic        armed_q, armed_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [38:0] tx_q, tx_d;
    logic [6:0]  rx_q, rx_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [1:0]  led_q, led_d;
    logic        miso_q, miso_d;
    logic        overrun_q, overrun_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic ss_s, sclk_s, mosi_s;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic cmd_valid;

    always_comb begin
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        ss_s        = ss_sync_q[SYNC_STAGES-1];
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        ss_hist_d   = ss_s;
        sclk_hist_d = sclk_s;
        ss_fall     = ss_hist_q & ~ss_s;
        ss_rise     = ~ss_hist_q & ss_s;
        sclk_rise   = ~sclk_hist_q & sclk_s;
        sclk_fall   = sclk_hist_q & ~sclk_s;
    end

`ifdef JSTK_CMD_CHECK_EN
    assign cmd_valid = (cmd_q[7:2] == 6'b100000);
`else
    logic unused_cmd_upper;
    assign unused_cmd_upper = ^cmd_q[7:2];
    assign cmd_valid        = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        cmd_d     = cmd_q;
        led_d     = led_q;
        miso_d    = miso_q;
        overrun_d = overrun_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            StIdle: begin
                miso_d = IDLE_MISO;
                if (ss_s) armed_d = 1'b1;
                if (ss_fall && armed_q) begin
                    // Bit 39 (x[7]) goes straight to miso; the rest waits in the shifter.
                    tx_d      = {x_pos[6:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8],
                                 5'b0, btn};
                    miso_d    = x_pos[7];
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    overrun_d = 1'b0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                // An ss_n rise takes priority over any coincident SCLK edge.
                if (ss_rise) begin
                    state_d = StIdle;
                    miso_d  = IDLE_MISO;
                    if (bit_cnt_q == FrameBits && !overrun_q) begin
                        done_d = 1'b1;
                        if (cmd_valid) led_d = cmd_q[1:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    if (bit_cnt_q == FrameBits) begin
                        overrun_d = 1'b1;
                    end else begin
                        rx_d      = {rx_q[5:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd7) cmd_d = {rx_q, mosi_s};
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q < FrameBits) begin
                        tx_d   = {tx_q[37:0], 1'b0};
                        miso_d = tx_q[38];
                    end else begin
                        miso_d = IDLE_MISO;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_hist_q   <= 1'b0;
            sclk_hist_q <= 1'b0;
            state_q     <= StIdle;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            cmd_q       <= '0;
            led_q       <= '0;
            miso_q      <= IDLE_MISO;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ss_sync_q   <= ss_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_hist_q   <= ss_hist_d;
            sclk_hist_q <= sclk_hist_d;
            state_q     <= state_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cmd_q       <= cmd_d;
            led_q       <= led_d;
            miso_q      <= miso_d;
            overrun_q   <= overrun_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign miso       = miso_q;
    assign led        = led_q;
    assign busy       = (state_q == StShift);
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: bit-banged SPI master at clk/8 with pulse counters.
module tb_jstk_spi_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss_n = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic [9:0] x_pos = '0;
    logic [9:0] y_pos = '0;
    logic [2:0] btn = '0;
    logic [1:0] led;
    logic       busy;
    logic       frame_done;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    jstk_spi_responder dut (
        .clk        (clk),
        .rst        (rst),
        .ss_n       (ss_n),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .btn        (btn),
        .led        (led),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always @(posedge clk) begin
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI mode-0 bit; miso is sampled just before the rising edge.
    task automatic spi_bit(input logic b, output logic m);
        mosi = b;
        wait_clk(4);
        m = miso;
        sclk = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input int nbits, input int chg_bit,
                             input logic [9:0] chg_x, output logic [40:0] rxd,
                             output logic busy_seen);
        logic m;
        logic b;
        logic [7:0] c;
        c = cmd;
        rxd = '0;
        busy_seen = 1'b0;
        ss_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            b = (i < 8) ? c[7-i] : 1'b0;
            spi_bit(b, m);
            rxd = {rxd[39:0], m};
            if (i == 4) busy_seen = busy;
            if (i + 1 == chg_bit) x_pos = chg_x;
        end
        wait_clk(4);
        ss_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(2);
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso); end
        checks++; if (led !== 2'b00) begin errors++; $display("FAIL reset_led got %b want 00", led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got %b%b want 00", frame_done, frame_err);
        end
        wait_clk(4);
    endtask

    task automatic test_basic();
        logic [40:0] r;
        logic bs;
        int d0, e0;
        logic [39:0] exp_f;
        x_pos = 10'h2A5; y_pos = 10'h13C; btn = 3'b101;
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(8'h83, 40, 0, 10'h0, r, bs);
        exp_f = 40'hA5_02_3C_01_05;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (r[39-8*k -: 8] !== exp_f[39-8*k -: 8]) begin
                errors++;
                $display("FAIL basic_byte%0d got %h want %h", k, r[39-8*k -: 8], exp_f[39-8*k -: 8]);
            end
        end
        checks++; if (bs !== 1'b1) begin errors++; $display("FAIL basic_busy_mid got %b want 1", bs); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done got %0d want 1", done_cnt - d0); end
        checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL basic_err got %0d want 0", err_cnt - e0); end
        checks++; if (led !== 2'b11) begin errors++; $display("FAIL basic_led got %b want 11", led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy); end
    endtask

    task automatic test_midframe_change();
        logic [40:0] r;
        logic bs;
        x_pos = 10'h2A5;
        spi_frame(8'h83, 40, 16, 10'h3FF, r, bs);
        checks++; if (r[39:24] !== 16'hA502) begin errors++; $display("FAIL chg_first got %h want a502", r[39:24]); end
        spi_frame(8'h83, 40, 0, 10'h0, r, bs);
        checks++; if (r[39:24] !== 16'hFF03) begin errors++; $display("FAIL chg_next got %h want ff03", r[39:24]); end
        x_pos = 10'h2A5;
    endtask

    task automatic test_abort();
        logic [40:0] r;
        logic bs;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(8'h00, 17, 0, 10'h0, r, bs);
        checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL abort_err got %0d want 1", err_cnt - e0); end
        checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL abort_done got %0d want 0", done_cnt - d0); end
        checks++; if (led !== 2'b11) begin errors++; $display("FAIL abort_led got %b want 11", led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL abort_miso got %b want 0", miso); end
    endtask

    task automatic test_overrun();
        logic [40:0] r;
        logic bs;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(8'h00, 41, 0, 10'h0, r, bs);
        checks++; if (r[8:1] !== 8'h05) begin errors++; $display("FAIL ovr_byte4 got %h want 05", r[8:1]); end
        checks++; if (r[0] !== 1'b0) begin errors++; $display("FAIL ovr_bit41 got %b want 0", r[0]); end
        checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL ovr_err got %0d want 1", err_cnt - e0); end
        checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL ovr_done got %0d want 0", done_cnt - d0); end
        checks++; if (led !== 2'b11) begin errors++; $display("FAIL ovr_led got %b want 11", led); end
    endtask

    task automatic test_cmd_check();
        logic [40:0] r;
        logic bs;
        int d0;
        logic [1:0] exp_led;
`ifdef JSTK_CMD_CHECK_EN
        exp_led = 2'b11;
`else
        exp_led = 2'b01;
`endif
        d0 = done_cnt;
        spi_frame(8'h41, 40, 0, 10'h0, r, bs);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL cmd41_done got %0d want 1", done_cnt - d0); end
        checks++; if (led !== exp_led) begin errors++; $display("FAIL cmd41_led got %b want %b", led, exp_led); end
    endtask

    task automatic test_rst_midframe();
        logic [40:0] r;
        logic bs;
        logic m;
        logic any_one;
        int d0, e0;
        x_pos = 10'h3FF; y_pos = 10'h3FF; btn = 3'b111;
        ss_n = 1'b0;
        for (int i = 0; i < 20; i++) spi_bit(1'b0, m);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre got %b want 1", busy); end
        d0 = done_cnt; e0 = err_cnt;
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        wait_clk(2);
        checks++; if (led !== 2'b00) begin errors++; $display("FAIL rstmid_led got %b want 00", led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso got %b want 0", miso); end
        any_one = 1'b0;
        for (int i = 0; i < 8; i++) begin
            spi_bit(1'b1, m);
            any_one = any_one | m;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_held got %b want 0", busy); end
        checks++; if (any_one !== 1'b0) begin errors++; $display("FAIL rstmid_miso_held got %b want 0", any_one); end
        wait_clk(4);
        ss_n = 1'b1;
        wait_clk(8);
        checks++; if (done_cnt != d0 || err_cnt != e0) begin
            errors++; $display("FAIL rstmid_pulses got %0d/%0d want 0/0", done_cnt - d0, err_cnt - e0);
        end
        x_pos = 10'h2A5; y_pos = 10'h13C; btn = 3'b101;
        spi_frame(8'h82, 40, 0, 10'h0, r, bs);
        checks++; if (r[39:0] !== 40'hA5_02_3C_01_05) begin
            errors++; $display("FAIL rstmid_frame got %h want a5023c0105", r[39:0]);
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rstmid_done got %0d want 1", done_cnt - d0); end
        checks++; if (led !== 2'b10) begin errors++; $display("FAIL rstmid_led_after got %b want 10", led); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_midframe_change();
        test_abort();
        test_overrun();
        test_cmd_check();
        test_rst_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
